// File: rtl/dm_slave.sv
// ---------------------------------------------------------------------------
// dm_slave -- data-memory responder for the M-stage data port of the
// pipelined MIPS core.
//
// It handles one request at a time. After a request is accepted, the block
// waits WAIT cycles, then commits the access. It returns the whole 32-bit
// word (the post-write value for writes) on a valid/ready response channel.
//
// Parameters
//   ADDR_W      word-address width; the memory holds 2^ADDR_W 32-bit words
//   WAIT        wait states between acceptance and commit (0..15)
//
// Ports
//   clk         single clock, rising edge
//   reset       asynchronous, active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (high in IDLE only)
//   req_addr    byte address; bits [1:0] are ignored
//   req_byteen  lane write mask; 4'b0000 means read
//   req_wdata   lane-replicated write data
//   resp_valid  response present (high in RESP only)
//   resp_ready  core accepts the response
//   resp_rdata  word content after the access (0 on error)
//   resp_err    address out of range; the access was suppressed
// ---------------------------------------------------------------------------
module dm_slave #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                oob_q, oob_d;
    logic [3:0]          byteen_q, byteen_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem [2**ADDR_W];
    logic [31:0]         rd_word_q;
    logic [31:0]         merged;
    logic                mem_we;
    logic                accept;

    // Byte offset bits play no part in word selection.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];

    assign accept = (state_q == S_IDLE) && req_valid;

    // Write lanes take new data; every other lane keeps the stored byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = byteen_q[gi] ? wdata_q[8*gi +: 8]
                                                    : rd_word_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        oob_d      = oob_q;
        byteen_d   = byteen_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    idx_d    = req_addr[ADDR_W+1:2];
                    oob_d    = |req_addr[31:ADDR_W+2];
                    byteen_d = req_byteen;
                    wdata_d  = req_wdata;
                    cnt_d    = WAIT_CNT;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_RESP;
                    if (oob_q) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                    end else begin
                        rdata_d = merged;
                        err_d   = 1'b0;
                        mem_we  = |byteen_q;
                    end
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            oob_q    <= 1'b0;
            byteen_q <= 4'd0;
            wdata_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oob_q    <= oob_d;
            byteen_q <= byteen_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Block RAM port. It is not reset. The old word is read at acceptance so
    // that it is ready at commit even with WAIT=0. Reads happen in IDLE and
    // writes happen at the end of BUSY, so the two never collide. mem_we
    // derives from state_q, so an asynchronous reset in BUSY suppresses the
    // pending write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= merged;
        end
        if (accept) begin
            rd_word_q <= mem[req_addr[ADDR_W+1:2]];
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
